seg7_mux_dimmer: RTL and testbench
==================================

Name: seg7_mux_dimmer

Overview:
- Display back-end of the dice design: consumes the `digit1`/`digit10` BCD values from the dice core and drives the two-digit common-cathode/anode 7-segment display.
- Time-multiplexes the two digits and applies PWM brightness from the I2C brightness register (duty out of 128).
- Applies the run-time segment and common polarity straps.

Parameters:
- MUX_DIV, 1024, clock cycles per digit slot; power of two, >=128.
- PWM_BITS, 7, width of duty input and PWM phase; fixed 7 (duty/128).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- digit1  in  4  units value: 0-9 digit, 10-14 dash, 15 blank
- digit10  in  4  tens value, same encoding
- blank_lz  in  1  1 = suppress tens digit when digit10==0
- duty  in  7  brightness; 0 = off, N = N/128 on-time
- seg_pol  in  1  level of a lit segment on seg_out
- com_pol  in  1  level of an active common
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}
- com1  out  1  units common
- com10  out  1  tens common
- frame  out  1  one-cycle pulse at start of each units slot

Behaviour:
- One clock; reset is synchronous and active-high.
- Prescaler `pcnt` counts 0..MUX_DIV-1 and wraps. `slot` toggles on wrap: 0 = units, 1 = tens.
- At pcnt==MUX_DIV-1, the inputs for the next slot are latched into `lat_val[3:0]`, `lat_blank` and `lat_duty`:
  - Inputs changing mid-slot have no visible effect until the next slot.
  - `lat_blank` = (next slot is tens) && blank_lz && digit10==0.
- PWM phase `ph` = pcnt[log2(MUX_DIV)-1 -: 7].
- Active condition: `on` = (ph < lat_duty) && !lat_blank && lat_val!=15.
- Internal registers, one-cycle latency from pcnt/slot:
  - `seg_r` <= on ? decode(lat_val) : 0
  - `c1_r` <= on && slot==0
  - `c10_r` <= on && slot==1
- Commons are never active simultaneously.
- Decode (g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, 10-14=40 (dash), 15=00. dp bit always 0 unless the optional feature is enabled.
- Output polarity, combinational:
  - seg_out = seg_pol ? seg_r : ~seg_r
  - com1 = (c1_r == 1) ? com_pol : ~com_pol; com10 likewise.
- `frame` registered: high for one cycle when pcnt==0 && slot==0.
- Duty boundaries:
  - duty=0 → commons never active.
  - duty=127 → active 127/128 of each slot; inactive in the last phase step before slot change, which acts as a ghosting guard.
- Reset:
  - pcnt=0, slot=0.
  - lat_val=15, lat_blank=1, lat_duty=0.
  - seg_r=0, c1_r=0, c10_r=0, frame=0.
  - Display is dark until the first slot boundary (MUX_DIV cycles after reset release).
- Reset asserted mid-slot clears everything on the same edge; the next cycle shows all commons inactive.

Optional Feature:
- Macro: SEG7_DP_EN.
- Defined:
  - Adds input port `dp1` (1 bit), latched with the units slot.
  - When set, segment bit 7 is lit in the units slot, subject to `on`.
  - dp is never lit in the tens slot.
- Undefined:
  - No `dp1` port.
  - seg_r[7] is constant 0.

Test Plan:
- MUX_DIV=256; reset high 3 cycles; digit1=7, digit10=4, duty=0x40, pols=1.
  - Display dark for the first 256 cycles.
  - Then units slot: com1 high for exactly 128 cycles, seg_out=07.
  - Tens slot: com10 high for 128 cycles, seg_out=66.
  - frame pulses every 512 cycles.
- duty=0x2B, MUX_DIV=256 → each common active 86 of 256 cycles per slot.
  - duty=0x01 → 2 cycles; duty=0x7F → 254 cycles; duty=0 → never.
- seg_pol=0, com_pol=0, digit1=3 → during active units phase seg_out=~4F=B0 and com1=0; when inactive, seg_out=FF and com1=com10=1.
- blank_lz=1, digit10=0, digit1=5 → tens slot never activates com10; with blank_lz=0 → tens shows 3F.
  - digit1=15 → units slot dark; digit1=12 → seg_out=40.
- Change digit1 from 2 to 8 at pcnt=100 of a units slot → seg_out stays 5B for the rest of that slot; 7F from the next units slot.
- Assert rst at pcnt=50 of a tens slot → next cycle com1=com10 inactive, seg_out all off. With SEG7_DP_EN and dp1=1, units seg_out=0x80|decode.

Source files
------------

// File: rtl/seg7_mux_dimmer_if.sv
// rtl/seg7_mux_dimmer_if.sv - digit/brightness inputs and display drive outputs of seg7_mux_dimmer (SEG7_DP_EN adds dp1)
interface seg7_mux_dimmer_if;
  logic [3:0] digit1;
  logic [3:0] digit10;
  logic       blank_lz;
  logic [6:0] duty;
  logic       seg_pol;
  logic       com_pol;
`ifdef SEG7_DP_EN
  logic       dp1;
`endif
  logic [7:0] seg_out;
  logic       com1;
  logic       com10;
  logic       frame;

  // Producer side: dice core / register block feeding the display back-end
  modport master (
`ifdef SEG7_DP_EN
    output dp1,
`endif
    output digit1, digit10, blank_lz, duty, seg_pol, com_pol,
    input  seg_out, com1, com10, frame
  );

  // Display back-end side
  modport slave (
`ifdef SEG7_DP_EN
    input  dp1,
`endif
    input  digit1, digit10, blank_lz, duty, seg_pol, com_pol,
    output seg_out, com1, com10, frame
  );
endinterface

// File: rtl/seg7_mux_dimmer.sv
// rtl/seg7_mux_dimmer.sv - two-digit 7-segment multiplexer with PWM dimming and polarity straps (optional SEG7_DP_EN)
module seg7_mux_dimmer #(
  parameter int MUX_DIV  = 1024,
  parameter int PWM_BITS = 7
) (
  input  logic               clk,
  input  logic               rst,
  seg7_mux_dimmer_if.slave   dsp
);

  localparam int CW = $clog2(MUX_DIV);

  logic [CW-1:0]       pcnt;
  logic                slot;
  logic                wrap;
  logic [3:0]          lat_val;
  logic                lat_blank;
  logic [PWM_BITS-1:0] lat_duty;
  logic [PWM_BITS-1:0] ph;
  logic                on;
  logic                dp_bit;
  logic [7:0]          seg_r;
  logic                c1_r;
  logic                c10_r;
  logic                frame_r;

  // Segment pattern {g,f,e,d,c,b,a}; 10-14 show a dash, 15 is blank
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      4'd15:   s = 7'h00;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign wrap = (pcnt == CW'(MUX_DIV - 1));

  // Slot prescaler: one full count per digit slot
  always_ff @(posedge clk) begin
    if (rst) pcnt <= '0;
    else     pcnt <= wrap ? '0 : pcnt + 1'b1;
  end

  // Digit slot select, flips at the end of every slot (0 = units, 1 = tens)
  always_ff @(posedge clk) begin
    if (rst)       slot <= 1'b0;
    else if (wrap) slot <= ~slot;
  end

  // Capture the next slot's digit and brightness so mid-slot changes stay invisible
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_val   <= 4'd15;
      lat_blank <= 1'b1;
      lat_duty  <= '0;
    end else if (wrap) begin
      lat_val   <= slot ? dsp.digit1 : dsp.digit10;
      lat_blank <= ~slot && dsp.blank_lz && (dsp.digit10 == 4'd0);
      lat_duty  <= dsp.duty;
    end
  end

`ifdef SEG7_DP_EN
  logic lat_dp;

  // Decimal point belongs to the units digit only; cleared when the tens slot starts
  always_ff @(posedge clk) begin
    if (rst)       lat_dp <= 1'b0;
    else if (wrap) lat_dp <= slot && dsp.dp1;
  end

  assign dp_bit = lat_dp;
`else
  assign dp_bit = 1'b0;
`endif

  // PWM phase is the top bits of the prescaler, so each slot holds exactly one PWM period;
  // duty <= 127 keeps the last phase step dark, separating the two commons in time
  assign ph = pcnt[CW-1 -: PWM_BITS];
  assign on = (ph < lat_duty) && !lat_blank && (lat_val != 4'd15);

  // Registered segment and common drive, internal active-high sense
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= '0;
      c1_r  <= 1'b0;
      c10_r <= 1'b0;
    end else begin
      seg_r <= on ? {dp_bit, decode(lat_val)} : 8'h00;
      c1_r  <= on && !slot;
      c10_r <= on && slot;
    end
  end

  // Frame marker at the start of each units slot
  always_ff @(posedge clk) begin
    if (rst) frame_r <= 1'b0;
    else     frame_r <= (pcnt == '0) && !slot;
  end

  assign dsp.seg_out = dsp.seg_pol ? seg_r : ~seg_r;
  assign dsp.com1    = c1_r  ? dsp.com_pol : ~dsp.com_pol;
  assign dsp.com10   = c10_r ? dsp.com_pol : ~dsp.com_pol;
  assign dsp.frame   = frame_r;

endmodule

// File: tb/tb_seg7_mux_dimmer.sv
// tb/tb_seg7_mux_dimmer.sv - randomized self-checking bench for seg7_mux_dimmer against a cycle-count reference model
module tb_seg7_mux_dimmer;

  localparam int M = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_mux_dimmer_if dif ();

  seg7_mux_dimmer #(.MUX_DIV(M), .PWM_BITS(7)) dut (
    .clk (clk),
    .rst (rst),
    .dsp (dif.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] dec_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // reference state: edges since reset release and the values shown in the current slot
  int         e = 0;
  bit         cur_valid = 0;
  int         cur_val = 15;
  bit         cur_blank = 1;
  int         cur_duty = 0;
  bit         cur_dp = 0;
  logic [7:0] x_seg = 8'h00;
  bit         x_c1 = 0;
  bit         x_c10 = 0;
  bit         x_frame = 0;
  int         cnt1 = 0;
  int         cnt10 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_dec(input int v);
    if (v == 15) return 7'h00;
    if (v >= 10) return 7'h40;
    return dec_tab[v];
  endfunction

  task automatic model_edge();
    int p;
    int k;
    bit tens;
    bit on;
    bit nt;
    if (rst) begin
      e = 0;
      cur_valid = 0;
      x_seg = 8'h00;
      x_c1 = 0;
      x_c10 = 0;
      x_frame = 0;
    end else begin
      p = e % M;
      k = e / M;
      tens = (k % 2) == 1;
      on = cur_valid && ((p * 128) / M < cur_duty) && !cur_blank && (cur_val != 15);
      x_seg = on ? {(!tens && cur_dp), ref_dec(cur_val)} : 8'h00;
      x_c1 = on && !tens;
      x_c10 = on && tens;
      x_frame = (e % (2 * M)) == 0;
      if (p == M - 1) begin
        nt = !tens;
        cur_valid = 1;
        cur_val = nt ? int'(dif.digit10) : int'(dif.digit1);
        cur_blank = nt && dif.blank_lz && (dif.digit10 == 4'd0);
        cur_duty = int'(dif.duty);
`ifdef SEG7_DP_EN
        cur_dp = !nt && dif.dp1;
`else
        cur_dp = 0;
`endif
      end
      e++;
    end
  endtask

  task automatic tick();
    logic [7:0] es;
    logic       e1;
    logic       e10;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    es  = dif.seg_pol ? x_seg : ~x_seg;
    e1  = x_c1 ? dif.com_pol : ~dif.com_pol;
    e10 = x_c10 ? dif.com_pol : ~dif.com_pol;
    chk("seg_out", dif.seg_out, es);
    chk("com1", dif.com1, e1);
    chk("com10", dif.com10, e10);
    chk("frame", dif.frame, x_frame);
    if (dif.com1 === dif.com_pol) cnt1++;
    if (dif.com10 === dif.com_pol) cnt10++;
  endtask

  // settle past two slot boundaries, then count active commons over one units+tens pair
  task automatic measure(input string tag, input int exp1, input int exp10);
    repeat (2 * M + 2) tick();
    cnt1 = 0;
    cnt10 = 0;
    repeat (2 * M) tick();
    chk({tag, "_on1"}, cnt1, exp1);
    chk({tag, "_on10"}, cnt10, exp10);
  endtask

  task automatic align(input string tag, input int pos);
    int g;
    g = 0;
    while ((e % (2 * M)) != pos && g < 4 * M) begin
      tick();
      g++;
    end
    chk({tag, "_align"}, e % (2 * M), pos);
  endtask

  initial begin
    dif.digit1   = 4'd7;
    dif.digit10  = 4'd4;
    dif.blank_lz = 1'b0;
    dif.duty     = 7'h40;
    dif.seg_pol  = 1'b1;
    dif.com_pol  = 1'b1;
`ifdef SEG7_DP_EN
    dif.dp1      = 1'b1;
`endif
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    cnt1 = 0;
    cnt10 = 0;
    repeat (M) tick();
    chk("dark_after_reset", cnt1 + cnt10, 0);

    measure("d40", 128, 128);
    dif.duty = 7'h2B; measure("d2b", 86, 86);
    dif.duty = 7'h01; measure("d01", 2, 2);
    dif.duty = 7'h7F; measure("d7f", 254, 254);
    dif.duty = 7'h00; measure("d00", 0, 0);

    dif.duty = 7'h40;
    dif.seg_pol = 1'b0;
    dif.com_pol = 1'b0;
    dif.digit1 = 4'd3;
    measure("pol0", 128, 128);

    dif.seg_pol = 1'b1;
    dif.com_pol = 1'b1;
    dif.blank_lz = 1'b1;
    dif.digit10 = 4'd0;
    dif.digit1 = 4'd5;
    measure("blank_lz", 128, 0);
    dif.blank_lz = 1'b0; measure("no_blank", 128, 128);
    dif.digit1 = 4'd15; measure("units_blank", 0, 128);
    dif.digit1 = 4'd12; measure("dash", 128, 128);

    dif.digit1 = 4'd2;
    repeat (2 * M + 2) tick();
    align("midslot", 100);
    dif.digit1 = 4'd8;
    measure("midslot", 128, 128);

    repeat (16 * M) begin
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 6))
          0: dif.digit1   = 4'($urandom_range(0, 15));
          1: dif.digit10  = 4'($urandom_range(0, 15));
          2: dif.blank_lz = 1'($urandom_range(0, 1));
          3: dif.duty     = 7'($urandom_range(0, 127));
          4: dif.seg_pol  = 1'($urandom_range(0, 1));
          5: dif.com_pol  = 1'($urandom_range(0, 1));
          default: begin
`ifdef SEG7_DP_EN
            dif.dp1 = 1'($urandom_range(0, 1));
`else
            dif.digit10 = 4'($urandom_range(0, 9));
`endif
          end
        endcase
      end
      tick();
    end

    dif.duty = 7'h7F;
    dif.digit1 = 4'd1;
    dif.digit10 = 4'd9;
    repeat (2 * M + 2) tick();
    align("rst_mid", M + 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt1 = 0;
    cnt10 = 0;
    repeat (M) tick();
    chk("dark_after_midrst", cnt1 + cnt10, 0);
    measure("after_rst", 254, 254);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
